// File: rtl/dnu_signexten_wr_ctrl_pkg.sv
// Shared constants helpers and FSM state type for the DNU sign-extension RAM write controller.
package dnu_signexten_wr_ctrl_pkg;

    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        StIdle,
        StCollect
    } wr_state_e;

endpackage

// File: rtl/signexten_beat_packer.sv
// Packs SUB_WIDTH-bit sign beats into one CHECK_PARALLELISM-bit word; word/word_ready include the
// beat being accepted this cycle.
module signexten_beat_packer
    import dnu_signexten_wr_ctrl_pkg::*;
#(
    parameter int unsigned CHECK_PARALLELISM = 85,
    parameter int unsigned SUB_WIDTH         = 17
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         beat_valid,
    input  logic [SUB_WIDTH-1:0]         sign_in,
    output logic [CHECK_PARALLELISM-1:0] word,
    output logic                         word_ready
);

    localparam int unsigned SUB_NUM = ceil_div(CHECK_PARALLELISM, SUB_WIDTH);
    localparam int unsigned BEAT_W  = cnt_width(SUB_NUM);
    localparam int unsigned PAD_W   = SUB_NUM * SUB_WIDTH;

    logic [BEAT_W-1:0] beat_idx_q;
    logic [BEAT_W-1:0] idx_eff;
    logic [PAD_W-1:0]  pack_q;
    logic [PAD_W-1:0]  base;
    logic [PAD_W-1:0]  merged;

    // clear restarts the word, so a beat arriving with it lands in lane group 0.
    always_comb begin
        idx_eff = clear ? '0 : beat_idx_q;
        base    = clear ? '0 : pack_q;
        merged  = base;
        for (int unsigned b = 0; b < SUB_NUM; b++) begin
            if (idx_eff == BEAT_W'(b)) begin
                merged[b*SUB_WIDTH +: SUB_WIDTH] = sign_in;
            end
        end
        word_ready = beat_valid && (idx_eff == BEAT_W'(SUB_NUM - 1));
        word       = merged[CHECK_PARALLELISM-1:0];
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            beat_idx_q <= '0;
            pack_q     <= '0;
        end else if (beat_valid) begin
            if (word_ready) begin
                beat_idx_q <= '0;
                pack_q     <= '0;
            end else begin
                beat_idx_q <= idx_eff + 1'b1;
                pack_q     <= merged;
            end
        end else if (clear) begin
            beat_idx_q <= '0;
            pack_q     <= '0;
        end
    end

endmodule

// File: rtl/dnu_signexten_wr_ctrl.sv
// Write-side controller for the DNU sign-extension RAM: packs sign beats and writes one word per
// row chunk. Optional macro SIGNEXTEN_DROP_CNT_EN adds the drop_cnt output.
module dnu_signexten_wr_ctrl
    import dnu_signexten_wr_ctrl_pkg::*;
#(
    parameter int unsigned ROW_CHUNK_NUM     = 9,
    parameter int unsigned CHECK_PARALLELISM = 85,
    parameter int unsigned SUB_WIDTH         = 17,
    localparam int unsigned SUB_NUM          = ceil_div(CHECK_PARALLELISM, SUB_WIDTH),
    localparam int unsigned ADDR_WIDTH       = cnt_width(ROW_CHUNK_NUM)
) (
    input  logic                         write_clk,
    input  logic                         rst,
    input  logic                         layer_start,
    input  logic [SUB_WIDTH-1:0]         sign_in,
    input  logic                         sign_valid,
    output logic [CHECK_PARALLELISM-1:0] signExten_din,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic                         we,
    output logic                         busy,
    output logic                         layer_done
`ifdef SIGNEXTEN_DROP_CNT_EN
    ,
    output logic [7:0]                   drop_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LastChunk = ADDR_WIDTH'(ROW_CHUNK_NUM - 1);

    wr_state_e                    state_q, state_d;
    logic [ADDR_WIDTH-1:0]        chunk_q, chunk_d, chunk_eff;
    logic                         beat_valid;
    logic                         word_ready;
    logic                         last_word;
    logic [CHECK_PARALLELISM-1:0] word;

    signexten_beat_packer #(
        .CHECK_PARALLELISM (CHECK_PARALLELISM),
        .SUB_WIDTH         (SUB_WIDTH)
    ) u_packer (
        .write_clk  (write_clk),
        .rst        (rst),
        .clear      (layer_start),
        .beat_valid (beat_valid),
        .sign_in    (sign_in),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        beat_valid = sign_valid && (layer_start || (state_q == StCollect));
        chunk_eff  = layer_start ? '0 : chunk_q;
        last_word  = word_ready && (chunk_eff == LastChunk);
        state_d    = state_q;
        chunk_d    = chunk_q;
        if (layer_start) begin
            state_d = StCollect;
            chunk_d = '0;
        end
        if (word_ready) begin
            chunk_d = last_word ? '0 : chunk_eff + 1'b1;
        end
        if (last_word) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge write_clk) begin
        if (rst) begin
            state_q       <= StIdle;
            chunk_q       <= '0;
            signExten_din <= '0;
            write_addr    <= '0;
            we            <= 1'b0;
            layer_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            we         <= word_ready;
            layer_done <= last_word;
            if (word_ready) begin
                signExten_din <= word;
                write_addr    <= chunk_eff;
            end
        end
    end

    assign busy = (state_q == StCollect);

`ifdef SIGNEXTEN_DROP_CNT_EN
    logic ignored;
    assign ignored = sign_valid && (state_q == StIdle) && !layer_start;

    always_ff @(posedge write_clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (ignored && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dnu_signexten_wr_ctrl.sv
// Directed self-checking bench for dnu_signexten_wr_ctrl at default parameters.
module tb_dnu_signexten_wr_ctrl;

    logic        write_clk = 1'b0;
    logic        rst = 1'b1;
    logic        layer_start = 1'b0;
    logic [16:0] sign_in = '0;
    logic        sign_valid = 1'b0;
    logic [84:0] signExten_din;
    logic [3:0]  write_addr;
    logic        we;
    logic        busy;
    logic        layer_done;
`ifdef SIGNEXTEN_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dnu_signexten_wr_ctrl dut (
        .write_clk     (write_clk),
        .rst           (rst),
        .layer_start   (layer_start),
        .sign_in       (sign_in),
        .sign_valid    (sign_valid),
        .signExten_din (signExten_din),
        .write_addr    (write_addr),
        .we            (we),
        .busy          (busy),
        .layer_done    (layer_done)
`ifdef SIGNEXTEN_DROP_CNT_EN
        ,
        .drop_cnt      (drop_cnt)
`endif
    );

    always #5 write_clk = ~write_clk;

    task automatic tick();
        @(posedge write_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word holding beats base..base+4, beat i in lanes i*17+:17.
    function automatic logic [84:0] mkword(input int base);
        logic [84:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            w[i*17 +: 17] = 17'(base + i);
        end
        return w;
    endfunction

    // Drive one beat; the sample after the edge reflects that beat.
    task automatic beat(input int val);
        sign_valid = 1'b1;
        sign_in    = 17'(val);
        tick();
        sign_valid = 1'b0;
    endtask

    task automatic run_layer(input int base);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("start_we", {127'd0, we}, 128'd0);
        chk("start_busy", {127'd0, busy}, 128'd1);
        for (int k = 0; k < 45; k++) begin
            sign_valid = 1'b1;
            sign_in    = 17'(base + k);
            tick();
            if (k % 5 == 4) begin
                chk("layer_we", {127'd0, we}, 128'd1);
                chk("layer_addr", {124'd0, write_addr}, 128'(k / 5));
                chk("layer_din", {43'd0, signExten_din}, {43'd0, mkword(base + k - 4)});
                chk("layer_done", {127'd0, layer_done}, (k == 44) ? 128'd1 : 128'd0);
            end else begin
                chk("layer_no_we", {127'd0, we}, 128'd0);
            end
        end
        sign_valid = 1'b0;
    endtask

    initial begin
        // Reset held 3 cycles.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_din", {43'd0, signExten_din}, 128'd0);
        chk("rst_addr", {124'd0, write_addr}, 128'd0);
        chk("rst_we", {127'd0, we}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, layer_done}, 128'd0);

        // Beat while idle is ignored.
        beat('h1FFFF);
        chk("idle_we", {127'd0, we}, 128'd0);
        chk("idle_busy", {127'd0, busy}, 128'd0);
`ifdef SIGNEXTEN_DROP_CNT_EN
        chk("idle_drop", {120'd0, drop_cnt}, 128'd1);
`endif

        // Full layer, back-to-back beats k = 0..44.
        run_layer(0);
        tick();
        chk("post_layer_busy", {127'd0, busy}, 128'd0);
        chk("post_layer_we", {127'd0, we}, 128'd0);
        chk("post_layer_hold", {43'd0, signExten_din}, {43'd0, mkword(40)});
        chk("post_layer_addr", {124'd0, write_addr}, 128'd8);

        // Gapped beats: chunks 0..2 with one idle cycle between beats.
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int j = 0; j < 15; j++) begin
            beat('h1000 + j);
            if (j % 5 == 4) begin
                chk("gap_we", {127'd0, we}, 128'd1);
                chk("gap_addr", {124'd0, write_addr}, 128'(j / 5));
                chk("gap_din", {43'd0, signExten_din}, {43'd0, mkword('h1000 + j - 4)});
            end else begin
                chk("gap_no_we", {127'd0, we}, 128'd0);
            end
            tick();
            chk("gap_idle_we", {127'd0, we}, 128'd0);
        end

        // Two beats of chunk 3, then abort.
        beat('h1ABC);
        beat('h1ABD);
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("abort_we", {127'd0, we}, 128'd0);
        chk("abort_busy", {127'd0, busy}, 128'd1);
        for (int j = 0; j < 5; j++) begin
            beat('h0500 + j);
            if (j < 4) chk("abort_no_we", {127'd0, we}, 128'd0);
        end
        chk("abort_we_after", {127'd0, we}, 128'd1);
        chk("abort_addr", {124'd0, write_addr}, 128'd0);
        chk("abort_din", {43'd0, signExten_din}, {43'd0, mkword('h0500)});

        // Reset on the 5th beat of chunk 1.
        for (int j = 0; j < 4; j++) beat('h0700 + j);
        rst        = 1'b1;
        sign_valid = 1'b1;
        sign_in    = 17'h0704;
        tick();
        rst        = 1'b0;
        sign_valid = 1'b0;
        chk("rstmid_we", {127'd0, we}, 128'd0);
        chk("rstmid_busy", {127'd0, busy}, 128'd0);
        chk("rstmid_din", {43'd0, signExten_din}, 128'd0);
        chk("rstmid_addr", {124'd0, write_addr}, 128'd0);
`ifdef SIGNEXTEN_DROP_CNT_EN
        chk("rstmid_drop", {120'd0, drop_cnt}, 128'd0);
`endif

        // layer_start together with beat 0.
        layer_start = 1'b1;
        sign_valid  = 1'b1;
        sign_in     = 17'h2000;
        tick();
        layer_start = 1'b0;
        chk("ls_beat_we", {127'd0, we}, 128'd0);
        for (int j = 1; j < 5; j++) beat('h2000 + j);
        chk("ls_beat_we_after", {127'd0, we}, 128'd1);
        chk("ls_beat_addr", {124'd0, write_addr}, 128'd0);
        chk("ls_beat_din", {43'd0, signExten_din}, {43'd0, mkword('h2000)});

        // Two consecutive layers, second starts the cycle after layer_done.
        run_layer('h3000);
        run_layer('h4000);
        tick();
        chk("final_busy", {127'd0, busy}, 128'd0);
        chk("final_done", {127'd0, layer_done}, 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
